bfp_stream: RTL

Sequential, parametrised successor to the combinational body-fat-percentage range block. It accepts one person record per handshake: weight, height, age and sex. It computes BMI with an iterative divider, derives body-fat percentage in hundredths, and classifies it into a sex-specific range. It keeps saturating per-sex, per-range population counters and sits between the record source and the reporting/display logic.

---
 rtl/bfp_pkg.sv | 34 +++
 rtl/bfp_div_seq.sv | 55 +++++
 rtl/bfp_stream.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bfp_pkg.sv
// Shared types and constants for the streaming body-fat-percentage block.
package bfp_pkg;

  typedef enum logic [2:0] {IDLE, MUL, DIV, CALC, HOLD} state_e;

  typedef enum logic [1:0] {CLS_LOW, CLS_FIT, CLS_AVG, CLS_OBESE} cls_e;

  localparam int unsigned K_BMI = 12;
  localparam int unsigned K_AGE = 23;
  localparam int unsigned K_SEX = 1080;
  localparam int unsigned K_OFS = 540;
  localparam int unsigned K_WT  = 100000;

  localparam logic [15:0] BFP_MAX = 16'd9999;

  localparam logic [15:0] F_LOW_LIM = 16'd2100;
  localparam logic [15:0] F_FIT_LIM = 16'd2500;
  localparam logic [15:0] F_AVG_LIM = 16'd3200;
  localparam logic [15:0] M_LOW_LIM = 16'd1400;
  localparam logic [15:0] M_FIT_LIM = 16'd1800;
  localparam logic [15:0] M_AVG_LIM = 16'd2500;

  function automatic logic [1:0] classify(input logic [15:0] v, input logic sx);
    logic [15:0] lo, fit, avg;
    lo  = sx ? M_LOW_LIM : F_LOW_LIM;
    fit = sx ? M_FIT_LIM : F_FIT_LIM;
    avg = sx ? M_AVG_LIM : F_AVG_LIM;
    if (v < lo)       return CLS_LOW;
    else if (v < fit) return CLS_FIT;
    else if (v < avg) return CLS_AVG;
    else              return CLS_OBESE;
  endfunction

endpackage

// File: rtl/bfp_div_seq.sv
// Restoring divider, one quotient bit per clock. Sequencing is left to the caller.
module bfp_div_seq #(
  parameter int unsigned Q = 25,
  parameter int unsigned D = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [Q-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic         done,
  output logic [Q-1:0] quotient
);
  localparam int unsigned CW = $clog2(Q + 1);

  logic [Q-1:0]  quo_q, quo_d;
  logic [D-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D:0]    rem_sh;
  logic          ge;

  always_comb begin
    rem_sh = {rem_q, quo_q[Q-1]};
    ge     = rem_sh >= {1'b0, divisor};
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      cnt_d = CW'(Q);
    end else if (cnt_q != '0) begin
      rem_d = ge ? D'(rem_sh - {1'b0, divisor}) : D'(rem_sh);
      quo_d = {quo_q[Q-2:0], ge};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  // High during the cycle whose closing edge shifts in the last quotient bit.
  assign done     = (cnt_q == CW'(1));
  assign quotient = quo_q;

endmodule

// File: rtl/bfp_stream.sv
// Sequential body-fat-percentage calculator with per-sex, per-class population counters.
module bfp_stream
  import bfp_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     wt,
  input  logic [W-1:0]     ht,
  input  logic [W-1:0]     age,
  input  logic             s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      bfp_x100,
  output logic [1:0]       bfprange,
  output logic             out_sex,
  output logic             err,
  input  logic             clr_stats,
  input  logic [2:0]       stat_sel,
  output logic [CNT_W-1:0] stat_count
);
  localparam int unsigned Q  = W + 17;
  localparam int unsigned D  = 2 * W;
  localparam int unsigned QC = Q + 6;

  state_e state_q, state_d;
  logic [W-1:0] wt_q, wt_d, ht_q, ht_d, age_q, age_d;
  logic         s_q, s_d;
  logic [15:0]  bfp_q, bfp_d;
  logic [1:0]   rng_q, rng_d;
  logic         sex_q, sex_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  logic [Q-1:0] dividend, quotient;
  logic [D-1:0] divisor;
  logic         div_start, div_done, hs;
  logic signed [QC-1:0] raw, sex_off;
  logic [15:0]  bfp_c;

  assign dividend  = Q'(wt_q) * Q'(K_WT);
  assign divisor   = D'(ht_q) * D'(ht_q);
  assign div_start = (state_q == MUL);

  bfp_div_seq #(.Q(Q), .D(D)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (quotient)
  );

  // QC bits comfortably hold 12*quotient plus the age term without wrap.
  always_comb begin
    sex_off = s_q ? signed'(QC'(K_SEX)) : signed'(QC'(0));
    raw = signed'(QC'(quotient)) * signed'(QC'(K_BMI))
        + signed'(QC'(age_q)) * signed'(QC'(K_AGE))
        - sex_off
        - signed'(QC'(K_OFS));
    if (raw[QC-1])                           bfp_c = '0;
    else if (raw > signed'(QC'(BFP_MAX)))    bfp_c = BFP_MAX;
    else                                     bfp_c = raw[15:0];
  end

  assign hs = (state_q == HOLD) && out_ready;

  always_comb begin
    state_d = state_q;
    wt_d    = wt_q;
    ht_d    = ht_q;
    age_d   = age_q;
    s_d     = s_q;
    bfp_d   = bfp_q;
    rng_d   = rng_q;
    sex_d   = sex_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        wt_d    = wt;
        ht_d    = ht;
        age_d   = age;
        s_d     = s;
        state_d = MUL;
      end
      MUL:  state_d = DIV;
      DIV:  if (div_done) state_d = CALC;
      CALC: begin
        sex_d   = s_q;
        err_d   = (ht_q == '0);
        bfp_d   = err_d ? 16'd0 : bfp_c;
        rng_d   = err_d ? CLS_LOW : classify(bfp_c, s_q);
        state_d = HOLD;
      end
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A clear in the handshake cycle overrides the increment.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_stats)
        cnt_d[i] = '0;
      else if (hs && !err_q && ({sex_q, rng_q} == 3'(i)) && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wt_q    <= '0;
      ht_q    <= '0;
      age_q   <= '0;
      s_q     <= 1'b0;
      bfp_q   <= '0;
      rng_q   <= '0;
      sex_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wt_q    <= wt_d;
      ht_q    <= ht_d;
      age_q   <= age_d;
      s_q     <= s_d;
      bfp_q   <= bfp_d;
      rng_q   <= rng_d;
      sex_q   <= sex_d;
      err_q   <= err_d;
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == HOLD);
  assign bfp_x100   = bfp_q;
  assign bfprange   = rng_q;
  assign out_sex    = sex_q;
  assign err        = err_q;
  assign stat_count = cnt_q[stat_sel];

endmodule
